// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the architectural PC and sequences one instruction fetch at a time:
// IDLE -> FETCH -> (WAIT)* -> ISSUE -> FETCH ..., with absorbing HALT and
// FAULT states that only Reset leaves.
//
// Ports
//   Clk, Reset          rising-edge clock, synchronous active-high reset
//   NextPC              next address from the PC select mux (taken on ISSUE->FETCH)
//   Stall, Halt         decode-side controls, sampled only in ISSUE
//   IMemReq/IMemAddr    fetch request and address (address == PCResult)
//   IMemReady/IMemData  memory response, sampled only in FETCH and WAIT
//   PCResult, PCPlus4   current PC and PC+4 (mod 2^32) for the mux
//   Instruction         captured instruction word
//   InstrValid          Instruction is valid for decode (ISSUE)
//   Halted, FetchFault  sticky status (HALT / FAULT states)
//   RetiredCount        retired instructions, wraps modulo 2^CNT_W
//   DbgState            registered FSM state for observation
//
// Handshake: IMemReq is high for every cycle of a fetch (FETCH plus any WAIT
// cycles) with IMemAddr stable; the fetch completes on the first of those
// cycles in which IMemReady is high, and IMemData is captured on that edge.
// IMemReady in any other cycle has no effect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      NextPC,
  input  logic             Stall,
  input  logic             Halt,
  output logic             IMemReq,
  output logic [31:0]      IMemAddr,
  input  logic             IMemReady,
  input  logic [31:0]      IMemData,
  output logic [31:0]      PCResult,
  output logic [31:0]      PCPlus4,
  output logic [31:0]      Instruction,
  output logic             InstrValid,
  output logic             Halted,
  output logic             FetchFault,
  output logic [CNT_W-1:0] RetiredCount,
  output logic [2:0]       DbgState
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  logic [2:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_retired;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_inc;
  logic [CNT_W-1:0] w_retired_inc;

  assign w_wait_inc    = r_wait_cnt + 8'd1;
  assign w_retired_inc = r_retired + CNT_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_retired  <= '0;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (IMemReady) begin
            r_instr <= IMemData;
            r_state <= ST_ISSUE;
          end else begin
            r_wait_cnt <= 8'd0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (IMemReady) begin
            r_instr <= IMemData;
            r_state <= ST_ISSUE;
          end else begin
            // The counter holds the number of WAIT cycles already spent, so
            // the fault is taken at the end of the MAX_WAIT-th WAIT cycle.
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == LP_MAX_WAIT) r_state <= ST_FAULT;
          end
        end
        ST_ISSUE: begin
          // Stall outranks Halt; a halt instruction still retires.
          if (!Stall) begin
            if (Halt) begin
              r_retired <= w_retired_inc;
              r_state   <= ST_HALT;
            end else if (NextPC[1:0] == 2'b00) begin
              r_pc      <= NextPC;
              r_retired <= w_retired_inc;
              r_state   <= ST_FETCH;
            end else begin
              r_state <= ST_FAULT;
            end
          end
        end
        ST_HALT:  r_state <= ST_HALT;
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // All control outputs are decoded from the registered state only.
  assign IMemReq      = (r_state == ST_FETCH) || (r_state == ST_WAIT);
  assign InstrValid   = (r_state == ST_ISSUE);
  assign Halted       = (r_state == ST_HALT);
  assign FetchFault   = (r_state == ST_FAULT);
  assign IMemAddr     = r_pc;
  assign PCResult     = r_pc;
  assign PCPlus4      = r_pc + 32'd4;
  assign Instruction  = r_instr;
  assign RetiredCount = r_retired;
  assign DbgState     = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int MAX_WAIT = 15;

  logic        Clk;
  logic        Reset;
  logic [31:0] NextPC;
  logic        Stall;
  logic        Halt;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] PCResult;
  logic [31:0] PCPlus4;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        Halted;
  logic        FetchFault;
  logic [31:0] RetiredCount;
  logic [2:0]  DbgState;

  // stimulus controls
  logic        use_seq;
  logic [31:0] next_pc_drv;
  int          mem_delay;
  logic        mem_never;
  logic        mem_force;
  int          req_cnt;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W(32)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .NextPC(NextPC),
    .Stall(Stall),
    .Halt(Halt),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemReady(IMemReady),
    .IMemData(IMemData),
    .PCResult(PCResult),
    .PCPlus4(PCPlus4),
    .Instruction(Instruction),
    .InstrValid(InstrValid),
    .Halted(Halted),
    .FetchFault(FetchFault),
    .RetiredCount(RetiredCount),
    .DbgState(DbgState)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {a[15:0], ~a[15:0]};
  endfunction

  // Instruction memory responder: req_cnt is the index of the current
  // request cycle within a run of consecutive request cycles.
  always @(posedge Clk) req_cnt <= IMemReq ? req_cnt + 1 : 0;
  assign IMemReady = mem_force || (IMemReq && !mem_never && (req_cnt >= mem_delay));
  assign IMemData  = IMemReady ? mem_word(IMemAddr) : 32'hDEAD_BEEF;
  assign NextPC    = use_seq ? PCPlus4 : next_pc_drv;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // scoreboard monitor: each entry into ISSUE is one presented instruction
  logic prev_valid;
  initial prev_valid = 1'b0;
  always @(negedge Clk) begin
    if (InstrValid && !prev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected: got pc=0x%08h instr=0x%08h expected none",
                 PCResult, Instruction);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({PCResult, Instruction} !== e) begin
          failures++;
          $display("FAIL issue: got pc=0x%08h instr=0x%08h expected pc=0x%08h instr=0x%08h",
                   PCResult, Instruction, e[63:32], e[31:0]);
        end
      end
    end
    prev_valid = InstrValid;
  end

  initial begin
    Reset = 1'b1; Stall = 1'b0; Halt = 1'b0;
    use_seq = 1'b1; next_pc_drv = 32'd0;
    mem_delay = 0; mem_never = 1'b0; mem_force = 1'b0;
    checks = 0; failures = 0;
    tick(2);
    // reset state (state IDLE in this cycle)
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_req", {31'd0, IMemReq}, 32'd0);
    chk("rst_count", RetiredCount, 32'd0);
    chk("rst_state", {29'd0, DbgState}, 32'd0);
    Reset = 1'b0;

    // sequential zero-wait fetches 0,4,8
    for (int i = 0; i < 3; i++) begin
      push_exp(32'(4 * i));
      tick(1);
      chk("seq_req", {31'd0, IMemReq}, 32'd1);
      chk("seq_addr", IMemAddr, 32'(4 * i));
      chk("seq_valid_lo", {31'd0, InstrValid}, 32'd0);
      tick(1);
      chk("seq_valid_hi", {31'd0, InstrValid}, 32'd1);
    end
    push_exp(32'h0C);
    tick(1);
    chk("seq_count3", RetiredCount, 32'd3);
    chk("seq_addr12", IMemAddr, 32'h0C);
    tick(1); // ISSUE at 0x0C
    mem_delay = 3;
    push_exp(32'h10);

    // delayed memory at 0x10: four request cycles with a stable address
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("wait_req", {31'd0, IMemReq}, 32'd1);
      chk("wait_addr", IMemAddr, 32'h10);
      chk("wait_valid_lo", {31'd0, InstrValid}, 32'd0);
    end
    tick(1);
    chk("wait_valid_hi", {31'd0, InstrValid}, 32'd1);
    chk("wait_instr", Instruction, mem_word(32'h10));

    // stall in ISSUE at 0x10 with NextPC=0x40
    mem_delay = 0;
    use_seq = 1'b0; next_pc_drv = 32'h40; Stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("stall_valid", {31'd0, InstrValid}, 32'd1);
      chk("stall_pc", PCResult, 32'h10);
      chk("stall_count", RetiredCount, 32'd4);
    end
    Stall = 1'b0;
    push_exp(32'h40);
    tick(1);
    chk("unstall_pc", PCResult, 32'h40);
    chk("unstall_count", RetiredCount, 32'd5);
    tick(1); // ISSUE at 0x40

    // PC+4 wrap boundary
    next_pc_drv = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC);
    tick(1);
    chk("wrap_pc", PCResult, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4, 32'h0);
    chk("wrap_count", RetiredCount, 32'd6);
    tick(1); // ISSUE at 0xFFFFFFFC

    // misaligned target
    next_pc_drv = 32'h42;
    tick(1);
    chk("mis_fault", {31'd0, FetchFault}, 32'd1);
    chk("mis_pc", PCResult, 32'hFFFF_FFFC);
    chk("mis_req", {31'd0, IMemReq}, 32'd0);
    chk("mis_valid", {31'd0, InstrValid}, 32'd0);
    chk("mis_count", RetiredCount, 32'd6);
    tick(3);
    chk("mis_fault_sticky", {31'd0, FetchFault}, 32'd1);
    chk("mis_req_sticky", {31'd0, IMemReq}, 32'd0);

    // fetch timeout: memory never ready
    Reset = 1'b1;
    tick(1);
    chk("rst2_fault", {31'd0, FetchFault}, 32'd0);
    chk("rst2_pc", PCResult, 32'h0);
    Reset = 1'b0; mem_never = 1'b1;
    tick(1); // FETCH
    for (int k = 0; k < MAX_WAIT; k++) begin
      tick(1);
      chk("to_no_fault", {31'd0, FetchFault}, 32'd0);
      chk("to_req", {31'd0, IMemReq}, 32'd1);
    end
    tick(1);
    chk("to_fault", {31'd0, FetchFault}, 32'd1);
    chk("to_req_lo", {31'd0, IMemReq}, 32'd0);

    // halt held off by stall
    Reset = 1'b1; mem_never = 1'b0; use_seq = 1'b1;
    tick(1);
    Reset = 1'b0;
    push_exp(32'h0);
    tick(2); // ISSUE at 0
    Stall = 1'b1; Halt = 1'b1;
    tick(1);
    chk("halt_stalled", {31'd0, Halted}, 32'd0);
    chk("halt_stalled_valid", {31'd0, InstrValid}, 32'd1);
    tick(1);
    chk("halt_stalled2", {31'd0, Halted}, 32'd0);
    Stall = 1'b0;
    tick(1);
    chk("halt_set", {31'd0, Halted}, 32'd1);
    chk("halt_count", RetiredCount, 32'd1);
    chk("halt_req", {31'd0, IMemReq}, 32'd0);
    chk("halt_valid", {31'd0, InstrValid}, 32'd0);
    chk("halt_pc", PCResult, 32'h0);
    Reset = 1'b1;
    tick(1);
    chk("halt_rst", {31'd0, Halted}, 32'd0);
    chk("halt_rst_pc", PCResult, 32'h0);
    Reset = 1'b0; Halt = 1'b0;

    // reset during WAIT at 0x20, then a late ready
    push_exp(32'h0);
    tick(2); // ISSUE at 0
    use_seq = 1'b0; next_pc_drv = 32'h20; mem_never = 1'b1;
    tick(2); // WAIT
    chk("rw_req", {31'd0, IMemReq}, 32'd1);
    chk("rw_addr", IMemAddr, 32'h20);
    tick(1);
    Reset = 1'b1;
    tick(1);
    chk("rw_req_lo", {31'd0, IMemReq}, 32'd0);
    chk("rw_pc", PCResult, 32'h0);
    chk("rw_instr", Instruction, 32'h0);
    Reset = 1'b0; mem_force = 1'b1;
    tick(1);
    chk("rw_late_ignored", Instruction, 32'h0);
    chk("rw_restart_addr", IMemAddr, 32'h0);
    chk("rw_restart_req", {31'd0, IMemReq}, 32'd1);
    mem_force = 1'b0; mem_never = 1'b0;
    push_exp(32'h0);
    tick(1); // ISSUE at 0
    tick(1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer; sits directly downstream of the PC select mux.
- Consumes the mux-selected next address (NextPC) and holds the architectural PC.
- Drives a req/ready handshake to instruction memory and presents one valid instruction at a time to decode.
- Supports stall, halt, misaligned-target detection and fetch timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles spent in WAIT without IMemReady before a fault is raised (1..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- NextPC  in  32  next address from the PC select mux.
- Stall  in  1  hold current instruction and PC.
- Halt  in  1  current instruction is a halt; sampled only in ISSUE.
- IMemReq  out  1  fetch request to instruction memory.
- IMemAddr  out  32  fetch address; always equals PCResult.
- IMemReady  in  1  memory data valid for the current request.
- IMemData  in  32  instruction word from memory.
- PCResult  out  32  current PC.
- PCPlus4  out  32  PCResult+4, combinational, modulo 2^32; this is the mux sequential input.
- Instruction  out  32  captured instruction word.
- InstrValid  out  1  Instruction is valid for decode.
- Halted  out  1  sticky halt indication.
- FetchFault  out  1  sticky fault: misaligned NextPC or timeout.
- RetiredCount  out  CNT_W  instructions retired; wraps modulo 2^CNT_W.

Behaviour:
- Reset (sampled on Clk edge while Reset=1), regardless of state:
  - state=IDLE; PCResult=RESET_PC; Instruction=0; InstrValid=0; IMemReq=0; Halted=0; FetchFault=0; RetiredCount=0; wait counter=0.
  - Reset overrides every other input in that cycle.
- States: IDLE, FETCH, WAIT, ISSUE, HALT, FAULT. All control outputs are Moore outputs of the registered state.
- IDLE:
  - IMemReq=0.
  - Goes to FETCH unconditionally on the next edge.
- FETCH:
  - IMemReq=1.
  - IMemReady=1 in this cycle: capture IMemData into Instruction and go to ISSUE.
  - Otherwise: clear the wait counter and go to WAIT.
- WAIT:
  - IMemReq=1; IMemAddr held stable.
  - IMemReady=1: capture IMemData and go to ISSUE.
  - Otherwise the wait counter increments; if the counter reaches MAX_WAIT, go to FAULT.
- ISSUE:
  - InstrValid=1; IMemReq=0.
  - Stall=1: remain in ISSUE; PC, Instruction and count all hold. Stall has priority over Halt.
  - Stall=0, Halt=1: RetiredCount+1; PC holds; go to HALT.
  - Stall=0, Halt=0, NextPC[1:0]==0: PCResult<=NextPC; RetiredCount+1; go to FETCH.
  - Stall=0, Halt=0, NextPC[1:0]!=0: PC holds; count holds; go to FAULT.
- HALT: Halted=1; IMemReq=0; InstrValid=0. Exit only via Reset.
- FAULT: FetchFault=1; IMemReq=0; InstrValid=0. Exit only via Reset.
- Throughput:
  - Zero-wait memory gives 2 cycles per instruction (FETCH, ISSUE).
  - Each WAIT cycle adds 1.
- IMemData is ignored outside FETCH and WAIT. IMemReady outside those states has no effect.
- Reset mid-WAIT:
  - IMemReq is low in the following cycle (IDLE).
  - The outstanding response is discarded.
- PC update occurs only on the ISSUE→FETCH transition. No other path modifies PCResult except reset.

Test Plan:
- Reset with RESET_PC=0, memory always ready, NextPC=PCPlus4:
  - After release: 1 cycle IDLE (IMemReq=0).
  - Then IMemAddr sequence 0,4,8 with InstrValid pulsing every 2nd cycle.
  - RetiredCount=3 after 3 issues.
- Memory ready delayed 3 cycles on address 0x10:
  - IMemReq high for 4 cycles with IMemAddr=0x10 stable.
  - Instruction=IMemData at the ready cycle; InstrValid the next cycle.
- In ISSUE, hold Stall=1 for 5 cycles with NextPC=0x40:
  - InstrValid stays 1; PCResult is unchanged.
  - After Stall drops: PCResult=0x40 and RetiredCount increments once only.
- In ISSUE, NextPC=0x42:
  - FetchFault=1; PCResult keeps its old value; IMemReq=0 and stays so until Reset.
  - Same fault with IMemReady never asserted: FetchFault rises exactly MAX_WAIT cycles after entering WAIT.
- In ISSUE, Halt=1 with Stall=1, then Stall=0:
  - No halt while stalled.
  - Next cycle: Halted=1, RetiredCount+1, IMemReq=0.
  - Assert Reset → Halted=0, PCResult=RESET_PC.
- Reset asserted during WAIT at address 0x20:
  - Next cycle IMemReq=0 and PCResult=RESET_PC.
  - A late IMemReady is ignored; the fetch restarts at RESET_PC.
